// File: rtl/mem_access_pkg.sv
// Shared encodings and small helpers for the MEM-stage memory access controller.
package mem_access_pkg;

  typedef enum logic [2:0] {
    OP_LW  = 3'd0,
    OP_LH  = 3'd1,
    OP_LHU = 3'd2,
    OP_LB  = 3'd3,
    OP_LBU = 3'd4,
    OP_SW  = 3'd5,
    OP_SH  = 3'd6,
    OP_SB  = 3'd7
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RD_ISSUE = 3'd1,
    ST_RD_WAIT  = 3'd2,
    ST_WR_ISSUE = 3'd3,
    ST_DONE     = 3'd4
  } state_e;

  function automatic logic is_load(op_e op);
    return (op == OP_LW) || (op == OP_LH) || (op == OP_LHU) ||
           (op == OP_LB) || (op == OP_LBU);
  endfunction

  // Sub-word stores cannot write a partial word, so they read it first.
  function automatic logic is_sub_store(op_e op);
    return (op == OP_SH) || (op == OP_SB);
  endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Pipeline request/response and data-memory bus seen by the MEM-stage controller.
interface mem_access_ctrl_if;
  logic        Req;
  logic [2:0]  Op;
  logic [31:0] Addr;
  logic [31:0] WData;
  logic        Stall;
  logic        Done;
  logic        Err;
  logic [31:0] LoadData;
  logic [31:0] MemAdr;
  logic [31:0] MemWrd;
  logic        MemR;
  logic        MemWr;
  logic [31:0] MemRd;

  // slave: the controller; master: the pipeline plus the data memory.
  modport slave (
    input  Req, Op, Addr, WData, MemRd,
    output Stall, Done, Err, LoadData, MemAdr, MemWrd, MemR, MemWr
  );

  modport master (
    output Req, Op, Addr, WData, MemRd,
    input  Stall, Done, Err, LoadData, MemAdr, MemWrd, MemR, MemWr
  );
endinterface

// File: rtl/mem_lane_align.sv
// Little-endian byte-lane handling: load extract/extend and sub-word store merge.
module mem_lane_align
  import mem_access_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  op_e         op,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] store_word
);

  logic [31:0] shifted;

  always_comb begin
    shifted   = word >> {lane, 3'b000};
    load_data = shifted;
    unique case (op)
      OP_LH:   load_data = {{16{shifted[15]}}, shifted[15:0]};
      OP_LHU:  load_data = {16'h0000, shifted[15:0]};
      OP_LB:   load_data = {{24{shifted[7]}}, shifted[7:0]};
      OP_LBU:  load_data = {24'h000000, shifted[7:0]};
      default: load_data = shifted;
    endcase
  end

  // Halfword lane is picked by lane[1] alone; lane[0] is 0 for any legal SH.
  always_comb begin
    store_word = wdata;
    unique case (op)
      OP_SB: begin
        store_word = word;
        store_word[{lane, 3'b000} +: 8] = wdata[7:0];
      end
      OP_SH: begin
        store_word = word;
        store_word[{lane[1], 4'b0000} +: 16] = wdata[15:0];
      end
      default: store_word = wdata;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage initiator: sequences one load/store against a 1-cycle registered-read
// data memory, doing read-modify-write for SB/SH and rejecting bad accesses.
module mem_access_ctrl
  import mem_access_pkg::*;
#(
  parameter int DEPTH_W = 8
) (
  input  logic               Clk,
  input  logic               Rst_n,
  mem_access_ctrl_if.slave   bus
);

  state_e      state, state_next;
  op_e         op_in, op_q;
  logic [1:0]  lane_q;
  logic [31:0] wdata_q;
  logic        err_q;
  logic        bad;
  logic [31:0] load_val;
  logic [31:0] merge_val;

  assign op_in = op_e'(bus.Op);

  always_comb begin
    bad = |bus.Addr[31:DEPTH_W+2];
    unique case (op_in)
      OP_LW, OP_SW:         bad = bad | (bus.Addr[1:0] != 2'b00);
      OP_LH, OP_LHU, OP_SH: bad = bad | bus.Addr[0];
      default:              bad = bad;
    endcase
  end

  mem_lane_align u_align (
    .word       (bus.MemRd),
    .lane       (lane_q),
    .op         (op_q),
    .wdata      (wdata_q),
    .load_data  (load_val),
    .store_word (merge_val)
  );

  // NOTE: every output and next-state gets a default first so no latch is inferred.
  always_comb begin
    state_next = state;
    bus.Stall  = 1'b0;
    bus.Done   = 1'b0;
    bus.Err    = 1'b0;
    bus.MemR   = 1'b0;
    bus.MemWr  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (bus.Req) begin
          bus.Stall = 1'b1;
          if (bad)                  state_next = ST_DONE;
          else if (op_in == OP_SW)  state_next = ST_WR_ISSUE;
          else                      state_next = ST_RD_ISSUE;
        end
      end
      ST_RD_ISSUE: begin
        bus.Stall  = 1'b1;
        bus.MemR   = Rst_n;
        state_next = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        bus.Stall  = 1'b1;
        state_next = is_load(op_q) ? ST_DONE : ST_WR_ISSUE;
      end
      ST_WR_ISSUE: begin
        // Gating with Rst_n keeps a reset in this cycle from committing a half-done RMW.
        bus.Stall  = 1'b1;
        bus.MemWr  = Rst_n;
        state_next = ST_DONE;
      end
      ST_DONE: begin
        bus.Done   = 1'b1;
        bus.Err    = err_q;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // NOTE: registers use non-blocking assignments so all of them see pre-edge values.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state        <= ST_IDLE;
      op_q         <= OP_LW;
      lane_q       <= 2'b00;
      wdata_q      <= '0;
      err_q        <= 1'b0;
      bus.LoadData <= '0;
      bus.MemAdr   <= '0;
      bus.MemWrd   <= '0;
    end else begin
      state <= state_next;
      if (state == ST_IDLE && bus.Req) begin
        op_q       <= op_in;
        lane_q     <= bus.Addr[1:0];
        wdata_q    <= bus.WData;
        err_q      <= bad;
        bus.MemAdr <= {{(32-DEPTH_W){1'b0}}, bus.Addr[DEPTH_W+1:2]};
        if (bad)                  bus.LoadData <= '0;
        else if (op_in == OP_SW)  bus.MemWrd   <= bus.WData;
      end
      if (state == ST_RD_WAIT) begin
        if (is_load(op_q)) bus.LoadData <= load_val;
        else               bus.MemWrd   <= merge_val;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: behavioural per-access model plus directed literals.
module tb_mem_access_ctrl;

  logic Clk;
  logic Rst_n;
  int   checks;
  int   failures;

  mem_access_ctrl_if bus ();

  mem_access_ctrl #(.DEPTH_W(8)) dut (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .bus   (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Data memory seen by the DUT: registered read, write at posedge.
  logic [31:0] mem     [0:255];
  logic [31:0] ref_mem [0:255];

  always @(posedge Clk) begin
    if (bus.MemWr === 1'b1) mem[bus.MemAdr[7:0]] <= bus.MemWrd;
    if (bus.MemR === 1'b1)  bus.MemRd <= mem[bus.MemAdr[7:0]];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Access-level model: decides error, latency, result and new word per access.
  logic        m_busy;
  int          m_cyc;
  int          m_lat;
  logic [2:0]  m_op;
  logic [31:0] m_addr;
  logic [31:0] m_wd;
  logic [7:0]  m_widx;
  logic        m_err;
  logic        m_is_load;
  logic        m_reads;
  logic [31:0] m_ld;
  logic [31:0] m_new;
  logic [31:0] m_w;
  logic [7:0]  m_byte;
  logic [15:0] m_half;
  int          m_bsh;
  int          m_hsh;
  logic        e_memr;
  logic        e_memwr;
  logic        e_done;

  always @(negedge Clk) begin
    if (Rst_n !== 1'b1) begin
      check("rst_memr", bus.MemR, 1'b0);
      check("rst_memwr", bus.MemWr, 1'b0);
      m_busy = 1'b0;
    end else begin
      if (!m_busy && bus.Req === 1'b1) begin
        m_op      = bus.Op;
        m_addr    = bus.Addr;
        m_wd      = bus.WData;
        m_widx    = m_addr[9:2];
        m_w       = ref_mem[m_widx];
        m_err     = (m_addr >= 32'd1024) ||
                    ((m_op == 3'd0 || m_op == 3'd5) && (m_addr % 4 != 0)) ||
                    ((m_op == 3'd1 || m_op == 3'd2 || m_op == 3'd6) && (m_addr % 2 != 0));
        m_is_load = (m_op <= 3'd4);
        m_reads   = m_is_load || (m_op >= 3'd6);
        m_lat     = m_err ? 1 : (m_op == 3'd5) ? 2 : (m_op >= 3'd6) ? 4 : 3;
        m_bsh     = 8 * int'(m_addr % 4);
        m_hsh     = 16 * int'((m_addr / 2) % 2);
        m_byte    = 8'((m_w >> m_bsh) & 32'hFF);
        m_half    = 16'((m_w >> m_hsh) & 32'hFFFF);
        case (m_op)
          3'd0:    m_ld = m_w;
          3'd1:    m_ld = {{16{m_half[15]}}, m_half};
          3'd2:    m_ld = {16'h0000, m_half};
          3'd3:    m_ld = {{24{m_byte[7]}}, m_byte};
          3'd4:    m_ld = {24'h000000, m_byte};
          default: m_ld = 32'h0;
        endcase
        if (m_err) m_ld = 32'h0;
        case (m_op)
          3'd5:    m_new = m_wd;
          3'd6:    m_new = (m_w & ~(32'hFFFF << m_hsh)) | ((m_wd & 32'hFFFF) << m_hsh);
          3'd7:    m_new = (m_w & ~(32'hFF << m_bsh)) | ((m_wd & 32'hFF) << m_bsh);
          default: m_new = m_w;
        endcase
        m_busy = 1'b1;
        m_cyc  = 0;
      end
      e_done  = m_busy && (m_cyc == m_lat);
      e_memr  = m_busy && !m_err && m_reads && (m_cyc == 1);
      e_memwr = m_busy && !m_err && !m_is_load && (m_cyc == m_lat - 1);
      check("stall", bus.Stall, m_busy ? (m_cyc < m_lat) : (bus.Req === 1'b1));
      check("done", bus.Done, e_done);
      check("err", bus.Err, e_done && m_err);
      check("memr", bus.MemR, e_memr);
      check("memwr", bus.MemWr, e_memwr);
      if (e_memr || e_memwr) check("memadr", bus.MemAdr, {24'h0, m_widx});
      if (e_memwr) check("memwrd", bus.MemWrd, m_new);
      if (e_done) begin
        if (m_is_load || m_err) check("loaddata", bus.LoadData, m_ld);
        if (!m_is_load && !m_err) ref_mem[m_widx] = m_new;
        m_busy = 1'b0;
      end else if (m_busy) begin
        m_cyc++;
      end
    end
  end

  // Issue one access; optionally pin latency/result/error to literal values.
  task automatic run_op(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wd,
                        input bit hold, input bit lit, input int exp_lat,
                        input logic [31:0] exp_ld, input logic exp_err);
    int got;
    logic [31:0] ld;
    logic er;
    @(posedge Clk); #2;
    bus.Req = 1'b1; bus.Op = op; bus.Addr = addr; bus.WData = wd;
    got = -1;
    ld  = '0;
    er  = 1'b0;
    for (int n = 0; n < 12; n++) begin
      @(negedge Clk);
      if (bus.Done === 1'b1) begin
        got = n; ld = bus.LoadData; er = bus.Err;
        break;
      end
    end
    if (got < 0) check("done_timeout", 32'd0, 32'd1);
    if (lit) begin
      check("lit_latency", got, exp_lat);
      check("lit_err", er, exp_err);
      if (op <= 3'd4 || exp_err) check("lit_loaddata", ld, exp_ld);
    end
    #1;
    if (!hold) bus.Req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    checks   = 0;
    failures = 0;
    m_busy   = 1'b0;
    m_cyc    = 0;
    for (int i = 0; i < 256; i++) begin
      mem[i]     = i;
      ref_mem[i] = i;
    end
    Rst_n = 1'b0;
    bus.Req = 1'b0; bus.Op = 3'd0; bus.Addr = '0; bus.WData = '0;
    repeat (3) @(posedge Clk);
    #2 Rst_n = 1'b1;
    @(negedge Clk);
    check("reset_stall", bus.Stall, 1'b0);
    check("reset_done", bus.Done, 1'b0);
    check("reset_err", bus.Err, 1'b0);
    check("reset_loaddata", bus.LoadData, 32'h0);
    check("reset_memadr", bus.MemAdr, 32'h0);
    check("reset_memwrd", bus.MemWrd, 32'h0);

    // Byte load from word 5.
    run_op(3'd3, 32'h14, 32'h0, 0, 1, 3, 32'h00000005, 1'b0);
    // Full-word store then sign/zero-extended sub-word loads.
    run_op(3'd5, 32'h20, 32'h80FF7F01, 0, 1, 2, 32'h0, 1'b0);
    run_op(3'd3, 32'h23, 32'h0, 0, 1, 3, 32'hFFFFFF80, 1'b0);
    run_op(3'd4, 32'h23, 32'h0, 0, 1, 3, 32'h00000080, 1'b0);
    run_op(3'd1, 32'h22, 32'h0, 0, 1, 3, 32'hFFFF80FF, 1'b0);
    run_op(3'd2, 32'h20, 32'h0, 0, 1, 3, 32'h00007F01, 1'b0);
    // Byte store read-modify-write, then read back.
    run_op(3'd7, 32'h31, 32'h000000AB, 0, 1, 4, 32'h0, 1'b0);
    run_op(3'd0, 32'h30, 32'h0, 0, 1, 3, 32'h0000AB0C, 1'b0);
    // Bad accesses: misaligned LH, misaligned SW, out of range LW.
    run_op(3'd1, 32'h13, 32'h0, 0, 1, 1, 32'h0, 1'b1);
    run_op(3'd5, 32'h22, 32'h12345678, 0, 1, 1, 32'h0, 1'b1);
    run_op(3'd0, 32'h400, 32'h0, 0, 1, 1, 32'h0, 1'b1);

    // Reset during the write cycle of an SH read-modify-write.
    @(posedge Clk); #2;
    bus.Req = 1'b1; bus.Op = 3'd6; bus.Addr = 32'h40; bus.WData = 32'h0000BEEF;
    repeat (3) @(posedge Clk);
    #2 Rst_n = 1'b0;
    @(negedge Clk);
    check("rmw_reset_memwr", bus.MemWr, 1'b0);
    @(posedge Clk); #2;
    Rst_n = 1'b1; bus.Req = 1'b0;
    @(negedge Clk);
    check("rmw_reset_stall", bus.Stall, 1'b0);
    check("rmw_reset_done", bus.Done, 1'b0);
    repeat (4) @(posedge Clk);
    check("rmw_reset_mem16", mem[16], 32'h00000010);
    run_op(3'd0, 32'h40, 32'h0, 0, 1, 3, 32'h00000010, 1'b0);

    // Req held high across three back-to-back loads.
    run_op(3'd0, 32'h08, 32'h0, 1, 1, 3, 32'h00000002, 1'b0);
    run_op(3'd0, 32'h20, 32'h0, 1, 1, 3, 32'h80FF7F01, 1'b0);
    run_op(3'd0, 32'h30, 32'h0, 0, 1, 3, 32'h0000AB0C, 1'b0);

    // Randomised accesses checked by the model.
    for (int k = 0; k < 200; k++) begin
      logic [2:0]  rop;
      logic [31:0] raddr;
      rop = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 7) == 0) raddr = $urandom() | 32'h400;
      else                           raddr = 32'($urandom_range(0, 1023));
      if ($urandom_range(0, 3) != 0) begin
        if (rop == 3'd0 || rop == 3'd5) raddr[1:0] = 2'b00;
        else if (rop == 3'd1 || rop == 3'd2 || rop == 3'd6) raddr[0] = 1'b0;
      end
      run_op(rop, raddr, $urandom(), $urandom_range(0, 1) == 1, 0, 0, 32'h0, 1'b0);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge Clk);
    end

    #1 bus.Req = 1'b0;
    repeat (6) @(posedge Clk);
    for (int i = 0; i < 256; i++) check("final_mem", mem[i], ref_mem[i]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
